cdb_arbiter: RTL and testbench



---
 rtl/cdb_pkg.sv | 25 ++
 rtl/cdb_arbiter_if.sv | 40 ++++
 rtl/cdb_arbiter_rr_pick2.sv | 42 ++++
 rtl/cdb_arbiter.sv | 124 ++++++++++++
 tb/tb_cdb_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cdb_pkg.sv
// Shared CDB types and constants for the arbiter, reservation stations and ROB.
package cdb_pkg;

    localparam int ROB_W  = 6;
    localparam int DATA_W = 32;

    typedef logic [ROB_W-1:0] rob_tag_t;

    // Tags at or above this value are never allocated by the ROB.
    localparam rob_tag_t INVALID_ROB = 6'b010000;

    typedef struct packed {
        logic              iscast;
        rob_tag_t          robNum;
        logic [DATA_W-1:0] data;
    } cdb_slot_t;

    // Value carried by a slot that broadcasts nothing this cycle.
    localparam cdb_slot_t IDLE_SLOT = '{iscast: 1'b0, robNum: INVALID_ROB, data: '0};

    function automatic logic tag_in_range(input rob_tag_t tag);
        return tag < INVALID_ROB;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester handshake and dual-slot CDB broadcast bundle.
interface cdb_arbiter_if
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ROB_W-1:0]  req_robNum;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      flush;

    logic                      CDBiscast;
    rob_tag_t                  CDBrobNum;
    logic [DATA_W-1:0]         CDBdata;
    logic                      CDBiscast2;
    rob_tag_t                  CDBrobNum2;
    logic [DATA_W-1:0]         CDBdata2;
    logic                      tag_error;

    // Requester / snooper side.
    modport master (
        output req_valid, req_robNum, req_data, flush,
        input  req_ready,
        input  CDBiscast, CDBrobNum, CDBdata,
        input  CDBiscast2, CDBrobNum2, CDBdata2,
        input  tag_error
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_robNum, req_data, flush,
        output req_ready,
        output CDBiscast, CDBrobNum, CDBdata,
        output CDBiscast2, CDBrobNum2, CDBdata2,
        output tag_error
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick2.sv
// Combinational round-robin finder: first and second set request at or after ptr_i.
module rr_pick2 #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_a_o,
    output logic [NUM_REQ-1:0] gnt_b_o,
    output logic               vld_a_o,
    output logic               vld_b_o,
    output logic [PTR_W-1:0]   idx_a_o,
    output logic [PTR_W-1:0]   idx_b_o
);

    // Walk the requests from the pointer with wrap-around, taking the first two hits.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_a_o = '0;
        gnt_b_o = '0;
        vld_a_o = 1'b0;
        vld_b_o = 1'b0;
        idx_a_o = '0;
        idx_b_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (req_i[idx]) begin
                if (!vld_a_o) begin
                    vld_a_o      = 1'b1;
                    gnt_a_o[idx] = 1'b1;
                    idx_a_o      = PTR_W'(idx);
                end else if (!vld_b_o) begin
                    vld_b_o      = 1'b1;
                    gnt_b_o[idx] = 1'b1;
                    idx_b_o      = PTR_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-slot CDB arbiter: one-entry holding buffer per requester, round-robin
// drain of up to two buffers per cycle onto registered broadcast slots.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic         clock,
    input  logic         reset,
    cdb_arbiter_if.slave bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    rob_tag_t          in_tag  [NUM_REQ];
    logic [DATA_W-1:0] in_data [NUM_REQ];
    logic [NUM_REQ-1:0] accept;
    logic [NUM_REQ-1:0] tag_bad;
    logic [NUM_REQ-1:0] load;

    logic [NUM_REQ-1:0] buf_valid_q, buf_valid_d;
    rob_tag_t           buf_tag_q  [NUM_REQ];
    logic [DATA_W-1:0]  buf_data_q [NUM_REQ];
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    cdb_slot_t          slot1_q, slot1_d;
    cdb_slot_t          slot2_q, slot2_d;
    logic               tag_error_q, tag_error_d;

    logic [NUM_REQ-1:0] gnt_a, gnt_b;
    logic               vld_a, vld_b;
    logic [PTR_W-1:0]   idx_a, idx_b;

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
        if (int'(idx) == NUM_REQ - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Unpack the flat request buses and classify each offer.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            in_tag[i]  = bus.req_robNum[i*ROB_W +: ROB_W];
            in_data[i] = bus.req_data[i*DATA_W +: DATA_W];
            accept[i]  = bus.req_valid[i] && !buf_valid_q[i] && !bus.flush;
            tag_bad[i] = !tag_in_range(in_tag[i]);
            load[i]    = accept[i] && !tag_bad[i];
        end
    end

    rr_pick2 #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i   (buf_valid_q),
        .ptr_i   (rr_ptr_q),
        .gnt_a_o (gnt_a),
        .gnt_b_o (gnt_b),
        .vld_a_o (vld_a),
        .vld_b_o (vld_b),
        .idx_a_o (idx_a),
        .idx_b_o (idx_b)
    );

    // Next-state: flush wipes buffers, slots and pointer; otherwise grant, clear and accept.
    always_comb begin
        buf_valid_d = (buf_valid_q & ~(gnt_a | gnt_b)) | load;
        tag_error_d = tag_error_q | (|(accept & tag_bad));
        slot1_d     = IDLE_SLOT;
        slot2_d     = IDLE_SLOT;
        rr_ptr_d    = rr_ptr_q;
        if (vld_a) begin
            slot1_d  = '{iscast: 1'b1, robNum: buf_tag_q[idx_a], data: buf_data_q[idx_a]};
            rr_ptr_d = ptr_after(idx_a);
        end
        if (vld_b) begin
            slot2_d  = '{iscast: 1'b1, robNum: buf_tag_q[idx_b], data: buf_data_q[idx_b]};
            rr_ptr_d = ptr_after(idx_b);
        end
        if (bus.flush) begin
            buf_valid_d = '0;
            slot1_d     = IDLE_SLOT;
            slot2_d     = IDLE_SLOT;
            rr_ptr_d    = '0;
        end
    end

    // Control and broadcast registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_valid_q <= '0;
            rr_ptr_q    <= '0;
            slot1_q     <= IDLE_SLOT;
            slot2_q     <= IDLE_SLOT;
            tag_error_q <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            slot1_q     <= slot1_d;
            slot2_q     <= slot2_d;
            tag_error_q <= tag_error_d;
        end
    end

    // Buffer payload is qualified by buf_valid_q, so it needs no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (load[i]) begin
                buf_tag_q[i]  <= in_tag[i];
                buf_data_q[i] <= in_data[i];
            end
        end
    end

    assign bus.req_ready  = ~buf_valid_q;
    assign bus.CDBiscast  = slot1_q.iscast;
    assign bus.CDBrobNum  = slot1_q.robNum;
    assign bus.CDBdata    = slot1_q.data;
    assign bus.CDBiscast2 = slot2_q.iscast;
    assign bus.CDBrobNum2 = slot2_q.robNum;
    assign bus.CDBdata2   = slot2_q.data;
    assign bus.tag_error  = tag_error_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter with NUM_REQ=4.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        cdb_slot_t s1;
        cdb_slot_t s2;
    } pair_t;

    localparam cdb_slot_t NONE = {1'b0, 6'd16, 32'd0};

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    pair_t exp_q[$];

    int cnt0, cnt3, gap3, max_gap3;

    cdb_arbiter_if #(.NUM_REQ(N)) bus();

    cdb_arbiter #(.NUM_REQ(N)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic cdb_slot_t bc(input logic [5:0] t, input logic [31:0] d);
        return {1'b1, t, d};
    endfunction

    function automatic pair_t observed();
        return {bus.CDBiscast, bus.CDBrobNum, bus.CDBdata,
                bus.CDBiscast2, bus.CDBrobNum2, bus.CDBdata2};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%0h required=%0h", tag, got, want);
        end
    endtask

    task automatic push(input cdb_slot_t a, input cdb_slot_t b);
        exp_q.push_back({a, b});
    endtask

    task automatic step(input string tag);
        pair_t got;
        pair_t want;
        @(posedge clk);
        @(negedge clk);
        got = observed();
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            want = exp_q.pop_front();
            chk(tag, got, want);
        end
    endtask

    task automatic set_req(input int i, input logic [5:0] t, input logic [31:0] d);
        bus.req_robNum[i*ROB_W +: ROB_W]   = t;
        bus.req_data[i*DATA_W +: DATA_W]   = d;
        bus.req_valid[i]                   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = '0;
        bus.req_robNum = '0;
        bus.req_data   = '0;
        bus.flush      = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_slots", observed(), {NONE, NONE});
        chk("rst_ready", bus.req_ready, 4'b1111);
        chk("rst_tag_error", bus.tag_error, 1'b0);
        rst = 1'b0;

        // Single request on requester 1.
        set_req(1, 6'd5, 32'h0000_00AA);
        push(NONE, NONE);
        step("single_accept");
        chk("single_ready_busy", bus.req_ready, 4'b1101);
        bus.req_valid = '0;
        push(bc(6'd5, 32'hAA), NONE);
        step("single_bcast");
        chk("single_ready_back", bus.req_ready, 4'b1111);
        push(NONE, NONE);
        step("single_pulse_end");

        // Flush with empty buffers returns the pointer to 0.
        bus.flush = 1'b1;
        push(NONE, NONE);
        step("ptr_flush");
        bus.flush = 1'b0;

        // Four simultaneous requests, tags 1..4.
        for (int i = 0; i < N; i++) set_req(i, 6'(i + 1), 32'h100 + i);
        push(NONE, NONE);
        step("four_accept");
        chk("four_ready_busy", bus.req_ready, 4'b0000);
        bus.req_valid = '0;
        push(bc(6'd1, 32'h100), bc(6'd2, 32'h101));
        step("four_cycle1");
        push(bc(6'd3, 32'h102), bc(6'd4, 32'h103));
        step("four_cycle2");
        push(NONE, NONE);
        step("four_idle");

        // Fairness: requesters 0 and 3 re-request whenever ready.
        cnt0 = 0; cnt3 = 0; gap3 = 0; max_gap3 = 0;
        for (int c = 0; c < 10; c++) begin
            set_req(0, 6'd3, 32'h1000 + c);
            set_req(3, 6'd12, 32'h3000 + c);
            for (int h = 0; h < 2; h++) begin
                if (h == 0) push(NONE, NONE);
                else push(bc(6'd3, 32'h1000 + c), bc(6'd12, 32'h3000 + c));
                step(h == 0 ? "fair_accept" : "fair_bcast");
                gap3++;
                if (bus.CDBiscast && bus.CDBrobNum == 6'd3) cnt0++;
                if (bus.CDBiscast2 && bus.CDBrobNum2 == 6'd3) cnt0++;
                if ((bus.CDBiscast && bus.CDBrobNum == 6'd12) ||
                    (bus.CDBiscast2 && bus.CDBrobNum2 == 6'd12)) begin
                    cnt3++;
                    gap3 = 0;
                end
                if (gap3 > max_gap3) max_gap3 = gap3;
            end
        end
        bus.req_valid = '0;
        chk("fair_count0", cnt0, 10);
        chk("fair_diff_le1", ((cnt0 > cnt3) ? cnt0 - cnt3 : cnt3 - cnt0) <= 1, 1);
        chk("fair_starve3_le2", max_gap3 <= 2, 1);

        // Flush on the grant edge with buffers 0 and 2 full.
        set_req(0, 6'd7, 32'h77);
        set_req(2, 6'd8, 32'h88);
        push(NONE, NONE);
        step("flush_accept");
        chk("flush_ready_busy", bus.req_ready, 4'b1010);
        bus.req_valid = '0;
        bus.flush     = 1'b1;
        push(NONE, NONE);
        step("flush_edge");
        chk("flush_ready", bus.req_ready, 4'b1111);
        bus.flush = 1'b0;
        push(NONE, NONE);
        step("flush_after1");
        push(NONE, NONE);
        step("flush_after2");

        // Invalid tag 16 on requester 2, then boundary tag 15.
        set_req(2, 6'd16, 32'hDEAD);
        push(NONE, NONE);
        step("badtag_edge");
        chk("badtag_error", bus.tag_error, 1'b1);
        chk("badtag_ready", bus.req_ready, 4'b1111);
        bus.req_valid = '0;
        push(NONE, NONE);
        step("badtag_nobcast");
        chk("badtag_sticky1", bus.tag_error, 1'b1);
        set_req(2, 6'd15, 32'h55);
        push(NONE, NONE);
        step("tag15_accept");
        chk("tag15_ready_busy", bus.req_ready, 4'b1011);
        bus.req_valid = '0;
        push(bc(6'd15, 32'h55), NONE);
        step("tag15_bcast");
        chk("badtag_sticky2", bus.tag_error, 1'b1);

        // Asynchronous reset with three buffers full; pointer now at 3.
        set_req(0, 6'd10, 32'hA0);
        set_req(1, 6'd11, 32'hA1);
        set_req(2, 6'd12, 32'hA2);
        push(NONE, NONE);
        step("areset_accept");
        bus.req_valid = '0;
        push(bc(6'd10, 32'hA0), bc(6'd11, 32'hA1));
        step("areset_bcast");
        chk("areset_ready_pre", bus.req_ready, 4'b1011);
        #2 rst = 1'b1;
        #1;
        chk("areset_slots", observed(), {NONE, NONE});
        chk("areset_ready", bus.req_ready, 4'b1111);
        chk("areset_tag_error", bus.tag_error, 1'b0);
        #1 rst = 1'b0;
        push(NONE, NONE);
        step("areset_after1");
        push(NONE, NONE);
        step("areset_after2");
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
